// File: rtl/pipe_link_if.sv
// Handshake bundle between two pipeline stages: producer side (in_*) and consumer side (out_*).
// A beat transfers on a side in any cycle where its valid and ready are both high; valid never waits on ready.
interface pipe_link_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // master: the environment driving the producer side and consuming the output
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // slave: the buffer itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_link.sv
// Inter-stage circular buffer with registered back-pressure, optional empty-buffer
// fall-through and a synchronous flush for redirects.
module pipe_link #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 2,
    parameter int FALLTHROUGH = 0,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    pipe_link_if.slave    link,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;

    logic empty;
    logic full;
    logic bypass_path;
    logic push;
    logic pop;
    logic bypass;
    logic write_en;
    logic read_adv;

    // Explicit wrap: DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty       = (cnt == '0);
        full        = (cnt == CW'(DEPTH));
        bypass_path = (FALLTHROUGH != 0) && empty;

        // Ready depends only on local state, flush and reset, never on out_ready.
        link.in_ready  = rst_n & ~flush_i & ~full;
        link.out_valid = rst_n & ~flush_i & (bypass_path ? link.in_valid : ~empty);
        link.out_data  = (bypass_path && rst_n) ? link.in_data : mem[rd_ptr];

        push     = link.in_valid & link.in_ready;
        pop      = link.out_valid & link.out_ready;
        bypass   = bypass_path & push & pop;
        write_en = push & ~bypass;
        read_adv = pop & ~bypass;

        cnt_nxt = cnt;
        case ({write_en, read_adv})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Storage is left as is; only the bookkeeping is discarded.
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (write_en) begin
                mem[wr_ptr] <= link.in_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (read_adv) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    assign count = cnt;

    cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(DEPTH));

endmodule

// File: doc/pipe_link.md
# pipe_link

Parametrised inter-stage buffer carrying one packed stage payload (if_id_t, id_ex_t, ex_lsu_t, lsu_wb_t or any future struct) between two pipeline stages with a valid/ready handshake. It replaces the single-register, valid-bit-only handoff. It adds configurable depth, back-pressure that does not propagate combinationally, an optional zero-latency fall-through mode, and a synchronous flush for branch/trap redirects. One instance sits on each IFU→IDU, IDU→EXU, EXU→LSU and LSU→WBU link.

## Interface
- WIDTH, 32: payload width in bits; instantiated as $bits(<stage struct>).
- DEPTH, 2: entries, 1..16. Any integer is legal; a power of two is not required.
- FALLTHROUGH, 0: 1 = an empty buffer presents in_data combinationally on the output.
- CW, $clog2(DEPTH+1): width of the occupancy counter (derived; do not override).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous discard of all entries (redirect/trap).
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  buffer accepts this cycle.
- in_data  in  WIDTH  producer payload.
- out_valid  out  1  head entry (or fall-through data) valid.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  head payload.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: circular array of DEPTH × WIDTH. Read pointer rd_ptr and write pointer wr_ptr each run 0..DEPTH-1 and wrap to 0 after DEPTH-1; wrap is explicit because DEPTH may be a non-power of two. A registered cnt tracks occupancy.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = rst_n & ~flush_i & (cnt != DEPTH). in_ready depends only on state, flush_i and reset, never on out_ready. There is no combinational ready path through the block.
- FALLTHROUGH=0:
  - out_valid = ~flush_i & (cnt != 0).
  - out_data = mem[rd_ptr].
- FALLTHROUGH=1, cnt==0:
  - out_valid = ~flush_i & in_valid; out_data = in_data.
  - If push & pop occur in the same cycle, the item bypasses: no write, pointers and cnt unchanged.
  - If push without pop, the item is stored normally.
- FALLTHROUGH=1, cnt>0: behaves exactly as FALLTHROUGH=0.
- Update rules, non-bypass:
  - push writes mem[wr_ptr] and advances wr_ptr.
  - pop advances rd_ptr.
  - cnt += push − pop; simultaneous push and pop leaves cnt unchanged.
- Full: in_ready=0, so a pop in that cycle does not admit a push until the next cycle. Throughput is 1 item per cycle for DEPTH≥2 and 1 per 2 cycles for DEPTH=1.
- Empty with FALLTHROUGH=0: out_valid=0 regardless of in_valid.
- Flush:
  - While flush_i=1, in_ready=0 and out_valid=0, so no transfer occurs that cycle.
  - On the edge, cnt, rd_ptr and wr_ptr go to 0. Storage contents are left unchanged and are don't-care.
  - Flush takes priority over every other update.
- count = cnt. It does not include a bypassed item.
- Producer contract: in_data must be held stable while in_valid=1 and in_ready=0. The bench asserts this; the block does not check it.

## Timing
- Reset (rst_n=0, asynchronous):
  - cnt=0, rd_ptr=0, wr_ptr=0, all mem entries = 0.
  - Outputs during reset: out_valid=0, in_ready=0, count=0, out_data=0.
- First edge after rst_n rises: in_ready=1 with no dead cycle. Deassertion of rst_n is synchronised externally.
- Reset asserted mid-transfer drops all entries immediately; no partial state survives.
- Latency, in_valid to out_valid:
  - FALLTHROUGH=0: 1 cycle.
  - FALLTHROUGH=1 with buffer empty: 0 cycles.
- Back-pressure: out_ready low for N cycles stalls the producer only after DEPTH items are buffered.
- Flush asserted for k consecutive cycles: buffer is empty after the first edge; in_ready and out_valid stay 0 for all k cycles and recover on the cycle after flush_i falls.
- Ordering: strict FIFO. No item is duplicated or lost except by flush or reset.

## Test plan
- Reset/idle, DEPTH=2, FALLTHROUGH=0: hold rst_n=0 for 3 cycles -> out_valid=0, in_ready=0, count=0, out_data=0. Release -> in_ready=1 on the next cycle.
- Streaming, DEPTH=2, FALLTHROUGH=0: push 0x1..0x8 on consecutive cycles with out_ready=1 -> out_data 0x1..0x8 in order, first one cycle after its push, one per cycle, count stays ≤1.
- Full/wrap, DEPTH=3 (non-power-of-two): out_ready=0, push 0xA,0xB,0xC,0xD -> in_ready=0 after the third push and 0xD is held. Then out_ready=1 -> output sequence 0xA,0xB,0xC,0xD with pointers wrapping 2→0 and count returning to 0.
- Fall-through, DEPTH=2, FALLTHROUGH=1: buffer empty, in_valid=1, in_data=0x55, out_ready=1 -> out_valid=1 and out_data=0x55 in the same cycle, count stays 0. Repeat with out_ready=0 -> item stored, count=1, and it is presented again next cycle.
- Flush, DEPTH=4: fill with 0x1..0x3, then assert flush_i with in_valid=1 and out_ready=1 -> no handshake that cycle, count=0 next cycle. A subsequent push of 0x9 emerges first.
- Async reset mid-stream: assert rst_n=0 between clock edges with count=2 -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
